ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/cotm32_pkg.sv | 28 ++
 rtl/muldiv_div_core.sv | 42 ++++
 rtl/ex_muldiv.sv | 177 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cotm32_pkg.sv
// Shared RV32M definitions: funct3 encodings of the M-extension ops and operand-signedness helpers.
package cotm32_pkg;

    typedef enum logic [2:0] {
        MULDIV_MUL    = 3'd0,
        MULDIV_MULH   = 3'd1,
        MULDIV_MULHSU = 3'd2,
        MULDIV_MULHU  = 3'd3,
        MULDIV_DIV    = 3'd4,
        MULDIV_DIVU   = 3'd5,
        MULDIV_REM    = 3'd6,
        MULDIV_REMU   = 3'd7
    } muldiv_op_t;

    function automatic logic op_is_div(muldiv_op_t op);
        return op inside {MULDIV_DIV, MULDIV_DIVU, MULDIV_REM, MULDIV_REMU};
    endfunction

    // MUL keeps only the low word, which is sign-agnostic, so it runs unsigned.
    function automatic logic op_rs1_signed(muldiv_op_t op);
        return op inside {MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM};
    endfunction

    function automatic logic op_rs2_signed(muldiv_op_t op);
        return op inside {MULDIV_MULH, MULDIV_DIV, MULDIV_REM};
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath on unsigned magnitudes; exposes the next-step quotient/remainder.
module muldiv_div_core (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quo_nxt,
    output logic [31:0] o_rem_nxt
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [32:0] shifted;
    logic [31:0] diff;
    logic        fits;

    // When the trial subtract fits, the true difference is below 2^32, so a 32-bit subtract suffices.
    assign shifted   = {rem_q, quo_q[31]};
    assign fits      = (shifted >= {1'b0, dvs_q});
    assign diff      = shifted[31:0] - dvs_q;
    assign o_rem_nxt = fits ? diff : shifted[31:0];
    assign o_quo_nxt = {quo_q[30:0], fits};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (i_load) begin
            rem_q <= '0;
            quo_q <= i_dividend;
            dvs_q <= i_divisor;
        end else if (i_step) begin
            rem_q <= o_rem_nxt;
            quo_q <= o_quo_nxt;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M unit: iterative shift-add multiply and restoring divide with stall/done handshake.
// Build option COTM32_MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle product.
module ex_muldiv
    import cotm32_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic        i_flush,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [4:0]         cnt;
    logic [31:0]        result_q;
    muldiv_op_t         op;
    muldiv_op_t         op_q;
    logic               neg_q;
    logic               rneg_q;
    logic               accept;
    logic               is_div;
    logic               rs1_neg;
    logic               rs2_neg;
    logic               div_zero;
    logic               div_ovf;
    logic signed [31:0] rs1_s;
    logic signed [31:0] rs2_s;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        quo_nxt;
    logic [31:0]        rem_nxt;

    function automatic logic [31:0] mul_select(muldiv_op_t sel, logic [63:0] prod, logic neg);
        logic [63:0] p;
        p = neg ? (64'd0 - prod) : prod;
        return (sel == MULDIV_MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] div_select(muldiv_op_t sel, logic [31:0] quo, logic [31:0] rem,
                                               logic qneg, logic rneg);
        if (sel == MULDIV_DIV || sel == MULDIV_DIVU)
            return qneg ? (32'd0 - quo) : quo;
        return rneg ? (32'd0 - rem) : rem;
    endfunction

    // Divide-by-zero and signed-overflow answers, resolved without iterating.
    function automatic logic [31:0] div_special(muldiv_op_t sel, logic [31:0] rs1, logic zero);
        if (sel == MULDIV_DIV || sel == MULDIV_DIVU)
            return zero ? 32'hFFFF_FFFF : 32'h8000_0000;
        return zero ? rs1 : 32'd0;
    endfunction

    assign op       = muldiv_op_t'(i_op);
    assign rs1_s    = i_rs1;
    assign rs2_s    = i_rs2;
    assign is_div   = op_is_div(op);
    assign rs1_neg  = op_rs1_signed(op) && (rs1_s < 0);
    assign rs2_neg  = op_rs2_signed(op) && (rs2_s < 0);
    assign a_mag    = rs1_neg ? (32'd0 - i_rs1) : i_rs1;
    assign b_mag    = rs2_neg ? (32'd0 - i_rs2) : i_rs2;
    assign div_zero = (i_rs2 == 32'd0);
    assign div_ovf  = op_rs2_signed(op) && is_div && (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);
    assign accept   = (state == S_IDLE) && i_valid && i_start && !i_flush && !i_rst;

    assign o_busy   = accept || (state == S_MUL) || (state == S_DIV);
    assign o_done   = (state == S_DONE) && !i_flush;
    assign o_result = result_q;

    muldiv_div_core u_div_core (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (accept && is_div),
        .i_step     ((state == S_DIV) && !i_flush),
        .i_dividend (a_mag),
        .i_divisor  (b_mag),
        .o_quo_nxt  (quo_nxt),
        .o_rem_nxt  (rem_nxt)
    );

`ifdef COTM32_MULDIV_FAST_MUL_EN
    logic [63:0] prod_fast;
    assign prod_fast = {32'd0, a_mag} * {32'd0, b_mag};
`else
    logic [63:0] mul_acc;
    logic [63:0] mul_mcand;
    logic [31:0] mul_mplier;
    logic [63:0] acc_nxt;
    assign acc_nxt = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            result_q <= '0;
            op_q     <= MULDIV_MUL;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
`ifndef COTM32_MULDIV_FAST_MUL_EN
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= op;
                        neg_q  <= rs1_neg ^ rs2_neg;
                        rneg_q <= rs1_neg;
                        cnt    <= '0;
                        if (is_div) begin
                            if (div_zero || div_ovf) begin
                                state    <= S_DONE;
                                result_q <= div_special(op, i_rs1, div_zero);
                            end else begin
                                state <= S_DIV;
                            end
                        end else begin
`ifdef COTM32_MULDIV_FAST_MUL_EN
                            state    <= S_DONE;
                            result_q <= mul_select(op, prod_fast, rs1_neg ^ rs2_neg);
`else
                            state      <= S_MUL;
                            mul_acc    <= '0;
                            mul_mcand  <= {32'd0, a_mag};
                            mul_mplier <= b_mag;
`endif
                        end
                    end
                end
                S_MUL: begin
`ifdef COTM32_MULDIV_FAST_MUL_EN
                    state <= S_IDLE;
`else
                    if (i_flush) begin
                        state <= S_IDLE;
                    end else begin
                        mul_acc    <= acc_nxt;
                        mul_mcand  <= {mul_mcand[62:0], 1'b0};
                        mul_mplier <= {1'b0, mul_mplier[31:1]};
                        cnt        <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state    <= S_DONE;
                            result_q <= mul_select(op_q, acc_nxt, neg_q);
                        end
                    end
`endif
                end
                S_DIV: begin
                    if (i_flush) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state    <= S_DONE;
                            result_q <= div_select(op_q, quo_nxt, rem_nxt, neg_q, rneg_q);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed RV32M vectors, flush and asynchronous-reset aborts.
module tb_ex_muldiv;
    import cotm32_pkg::*;

    logic        i_clk   = 1'b0;
    logic        i_rst   = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_start = 1'b0;
    logic        i_flush = 1'b0;
    logic [2:0]  i_op    = 3'd0;
    logic [31:0] i_rs1   = 32'd0;
    logic [31:0] i_rs2   = 32'd0;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;

    exp_t sb[$];

`ifdef COTM32_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;
    localparam int SPC_LAT = 1;

    ex_muldiv dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_flush  (i_flush),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every o_done pulse must match the oldest outstanding expectation.
    always begin : monitor
        exp_t e;
        @(negedge i_clk);
        #3;
        if (o_done) begin
            if (sb.size() == 0) begin
                check("done_unexpected", {31'd0, o_done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", o_result, e.res);
                check("done_cycle", cyc, e.at);
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        i_valid = 1'b1;
        i_start = 1'b1;
        i_op    = op;
        i_rs1   = a;
        i_rs2   = b;
    endtask

    // Holds the instruction (as ID/EX would) until o_done, then drops it at the following negedge.
    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            @(negedge i_clk);
            #2;
            if (o_done) begin
                check("busy_in_done", {31'd0, o_busy}, 32'd0);
                seen = 1'b1;
            end else begin
                check("busy_running", {31'd0, o_busy}, 32'd1);
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_start = 1'b0;
        #2;
        check("busy_after_done", {31'd0, o_busy}, 32'd0);
        check("no_done_after", {31'd0, o_done}, 32'd0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input int lat);
        @(negedge i_clk);
        drive(op, a, b);
        sb.push_back('{res: r, at: cyc + lat});
        #2;
        check("busy_accept", {31'd0, o_busy}, 32'd1);
        wait_done();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin : stim
        #3;
        check("rst_result", o_result, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        issue(MULDIV_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        issue(MULDIV_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        issue(MULDIV_MULH,   32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, MUL_LAT);
        issue(MULDIV_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT);
        issue(MULDIV_MULHSU, 32'd2,          32'h8000_0000, 32'h0000_0001, MUL_LAT);
        issue(MULDIV_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        issue(MULDIV_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT);
        issue(MULDIV_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT);
        issue(MULDIV_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, SPC_LAT);
        issue(MULDIV_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         SPC_LAT);
        issue(MULDIV_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
        issue(MULDIV_REM,    32'd7,          32'd0,         32'd7,         SPC_LAT);
        issue(MULDIV_REMU,   32'd100,        32'd7,         32'd2,         DIV_LAT);
        issue(MULDIV_DIVU,   32'hFFFF_FFFF,  32'd16,        32'h0FFF_FFFF, DIV_LAT);
        issue(MULDIV_DIV,    32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, DIV_LAT);
        issue(MULDIV_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         DIV_LAT);

        // Flush in cycle 10 of a divide; a new start in cycle 11 must be accepted.
        @(negedge i_clk);
        drive(MULDIV_DIV, 32'd1000, 32'd3);
        repeat (10) @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        drive(MULDIV_DIVU, 32'd100, 32'd7);
        sb.push_back('{res: 32'd14, at: cyc + DIV_LAT});
        #2;
        check("busy_restart_after_flush", {31'd0, o_busy}, 32'd1);
        wait_done();

        // Asynchronous reset in cycle 5 of a divide.
        @(negedge i_clk);
        drive(MULDIV_DIV, 32'd1000, 32'd3);
        repeat (5) @(negedge i_clk);
        #1;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_start = 1'b0;
        #1;
        check("async_rst_result", o_result, 32'd0);
        check("async_rst_busy", {31'd0, o_busy}, 32'd0);
        check("async_rst_done", {31'd0, o_done}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #2;
        check("post_rst_busy", {31'd0, o_busy}, 32'd0);
        repeat (40) @(negedge i_clk);

        repeat (3) @(negedge i_clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
